jtag_tap: RTL



---
 rtl/jtag_tap_if.sv | 28 ++
 rtl/jtag_tap.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_if.sv
// JTAG TAP pin/strobe bundle: the driver side uses master, the TAP uses slave.
interface jtag_tap_if #(
    parameter int unsigned IR_WIDTH = 4
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_en;
    logic [IR_WIDTH-1:0] ir;
    logic                user_sel;
    logic                user_capture;
    logic                user_shift;
    logic                user_update;
    logic                user_tdo;
    logic                tap_reset;

    // Cable driver plus user data register side
    modport master (
        output tms, tdi, user_tdo,
        input  tdo, tdo_en, ir, user_sel, user_capture, user_shift, user_update, tap_reset
    );

    // TAP controller side
    modport slave (
        input  tms, tdi, user_tdo,
        output tdo, tdo_en, ir, user_sel, user_capture, user_shift, user_update, tap_reset
    );
endinterface

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, IDCODE/BYPASS DRs, user DR strobes.
module jtag_tap #(
    parameter int unsigned         IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 4'b0001,
    parameter logic [IR_WIDTH-1:0] INSTR_DEBUG  = 4'b1000
) (
    input  logic         tck,
    input  logic         trstn,
    jtag_tap_if.slave    bus
);

    localparam int unsigned DR_ID_WIDTH = 32;

    typedef enum logic [3:0] {
        ST_TLR     = 4'd0,
        ST_RTI     = 4'd1,
        ST_SEL_DR  = 4'd2,
        ST_CAP_DR  = 4'd3,
        ST_SH_DR   = 4'd4,
        ST_EX1_DR  = 4'd5,
        ST_PAU_DR  = 4'd6,
        ST_EX2_DR  = 4'd7,
        ST_UPD_DR  = 4'd8,
        ST_SEL_IR  = 4'd9,
        ST_CAP_IR  = 4'd10,
        ST_SH_IR   = 4'd11,
        ST_EX1_IR  = 4'd12,
        ST_PAU_IR  = 4'd13,
        ST_EX2_IR  = 4'd14,
        ST_UPD_IR  = 4'd15
    } state_e;

    state_e                  state_q, state_d;
    logic [IR_WIDTH-1:0]     ir_q, ir_d;
    logic [IR_WIDTH-1:0]     ir_sr_q, ir_sr_d;
    logic [DR_ID_WIDTH-1:0]  id_sr_q, id_sr_d;
    logic                    bypass_q, bypass_d;
    logic                    tdo_q;
    logic                    tdo_en_q;

    logic tlr_c, cap_dr_c, sh_dr_c, upd_dr_c, cap_ir_c, sh_ir_c, upd_ir_c;
    logic sel_id_c, sel_user_c;
    logic tdo_c;

    // FSM state register
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state from tms
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_TLR:    state_d = bus.tms ? ST_TLR    : ST_RTI;
            ST_RTI:    state_d = bus.tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_d = bus.tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_d = bus.tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_d = bus.tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_d = bus.tms ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_d = bus.tms ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_d = bus.tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_d = bus.tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_d = bus.tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_d = bus.tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_d = bus.tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_d = bus.tms ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_d = bus.tms ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_d = bus.tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_d = bus.tms ? ST_SEL_DR : ST_RTI;
            default:   state_d = ST_TLR;
        endcase
    end

    // FSM state decode into action strobes
    always_comb begin
        tlr_c    = 1'b0;
        cap_dr_c = 1'b0;
        sh_dr_c  = 1'b0;
        upd_dr_c = 1'b0;
        cap_ir_c = 1'b0;
        sh_ir_c  = 1'b0;
        upd_ir_c = 1'b0;
        unique case (state_q)
            ST_TLR:    tlr_c    = 1'b1;
            ST_CAP_DR: cap_dr_c = 1'b1;
            ST_SH_DR:  sh_dr_c  = 1'b1;
            ST_UPD_DR: upd_dr_c = 1'b1;
            ST_CAP_IR: cap_ir_c = 1'b1;
            ST_SH_IR:  sh_ir_c  = 1'b1;
            ST_UPD_IR: upd_ir_c = 1'b1;
            default:   ;
        endcase
    end

    // DR selection decoded from the active instruction; anything unknown is BYPASS
    always_comb begin
        sel_id_c   = (ir_q == INSTR_IDCODE);
        sel_user_c = (ir_q == INSTR_DEBUG);
    end

    // Shift/capture/update next values; pause and exit states simply hold
    always_comb begin
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        id_sr_d  = id_sr_q;
        bypass_d = bypass_q;
        if (tlr_c) begin
            ir_d = INSTR_IDCODE;
        end else if (upd_ir_c) begin
            ir_d = ir_sr_q;
        end
        if (cap_ir_c) begin
            ir_sr_d = IR_WIDTH'(2'b01);
        end else if (sh_ir_c) begin
            ir_sr_d = {bus.tdi, ir_sr_q[IR_WIDTH-1:1]};
        end
        if (cap_dr_c && sel_id_c) begin
            id_sr_d = IDCODE_VALUE;
        end else if (sh_dr_c && sel_id_c) begin
            id_sr_d = {bus.tdi, id_sr_q[DR_ID_WIDTH-1:1]};
        end
        if (cap_dr_c && !sel_id_c && !sel_user_c) begin
            bypass_d = 1'b0;
        end else if (sh_dr_c && !sel_id_c && !sel_user_c) begin
            bypass_d = bus.tdi;
        end
    end

    // Instruction and data shift registers, rising edge
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_q     <= INSTR_IDCODE;
            ir_sr_q  <= '0;
            id_sr_q  <= '0;
            bypass_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            id_sr_q  <= id_sr_d;
            bypass_q <= bypass_d;
        end
    end

    // Serial output source by state
    always_comb begin
        tdo_c = 1'b0;
        if (sh_ir_c) begin
            tdo_c = ir_sr_q[0];
        end else if (sh_dr_c) begin
            if (sel_id_c) begin
                tdo_c = id_sr_q[0];
            end else if (sel_user_c) begin
                tdo_c = bus.user_tdo;
            end else begin
                tdo_c = bypass_q;
            end
        end
    end

    // tdo/tdo_en launched on the falling edge so the driver samples mid-cycle
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_c;
            tdo_en_q <= sh_ir_c | sh_dr_c;
        end
    end

    // Output wiring; user strobes follow state directly
    assign bus.tdo          = tdo_q;
    assign bus.tdo_en       = tdo_en_q;
    assign bus.ir           = ir_q;
    assign bus.user_sel     = sel_user_c;
    assign bus.user_capture = sel_user_c & cap_dr_c;
    assign bus.user_shift   = sel_user_c & sh_dr_c;
    assign bus.user_update  = sel_user_c & upd_dr_c;
    assign bus.tap_reset    = tlr_c;

endmodule
